// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one fixed-latency single-port RAM between fetch and data channels
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              ramREN,
    output logic              ramWEN,
    input  logic [DATA_W-1:0] ramload
);
    localparam int CW = $clog2(RAM_LAT + 1);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;
    state_t        state;
    logic          last_d;
    logic          d_req;
    logic          grant_d;
    logic          grant_w;
    logic [CW-1:0] cnt;
    assign d_req   = dREN | dWEN;
    assign grant_d = d_req & (~iREN | ~last_d);
    assign grant_w = grant_d & dWEN;
    // the ram* registers double as the latched command for the whole access
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            cnt      <= '0;
            iload    <= '0;
            dload    <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: if (d_req | iREN) begin
                    state    <= grant_d ? DBUSY : IBUSY;
                    last_d   <= grant_d;
                    cnt      <= CW'(RAM_LAT - 1);
                    ramaddr  <= grant_d ? daddr : iaddr;
                    ramstore <= grant_w ? dstore : '0;
                    ramREN   <= ~grant_w;
                    ramWEN   <= grant_w;
                end
                IBUSY, DBUSY: if (cnt == '0) begin
                    state    <= DONE;
                    ihit     <= state == IBUSY;
                    dhit     <= state == DBUSY;
                    ramaddr  <= '0;
                    ramstore <= '0;
                    ramREN   <= 1'b0;
                    ramWEN   <= 1'b0;
                    if (ramREN && state == IBUSY) iload <= ramload;
                    if (ramREN && state == DBUSY) dload <= ramload;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
